// File: rtl/multicycle_uc.sv
// multicycle_uc: control unit for a multicycle RISC-V datapath with one
// shared ALU and one shared instruction/data memory. Supports lw, sw,
// R-type ALU, I-type ALU, beq and jal. Unknown opcodes park the unit in a
// trap state until reset. Retired instructions are counted in instret.
//
// Memory handshake: memReq is held high for the whole access, with its
// address/write qualifiers (adrSrc, memWrite) stable. The access completes
// on the first clock edge where memReq and memReady are both high. memReady
// is ignored while memReq is low. While rst is held, no access is requested.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   op, func3, func7    instruction fields from the IR (func7 = funct7[5])
//   zero                ALU zero flag, used by beq
//   memReady            memory completes the current access this cycle
//   memReq, memWrite    memory request and write qualifier
//   irWrite, pcWrite    IR and PC load enables
//   regWrite            register file write enable
//   adrSrc              memory address mux: 0 = PC, 1 = result
//   resultSrc           result mux: 00 ALUOut, 01 read data, 10 ALU result
//   aluSrcA, aluSrcB    ALU operand muxes
//   aluControl          000 add, 001 sub, 010 and, 011 or, 101 slt
//   immSrc              immediate format: 00 I, 01 S, 10 B, 11 J
//   illegal             trap indicator
//   instret             retired-instruction count, wraps modulo 2^CNT_W
//   dbg_state           current FSM state encoding, for observation only
module multicycle_uc #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       op,
    input  logic [2:0]       func3,
    input  logic             func7,
    input  logic             zero,
    input  logic             memReady,
    output logic             memReq,
    output logic             memWrite,
    output logic             irWrite,
    output logic             pcWrite,
    output logic             regWrite,
    output logic             adrSrc,
    output logic [1:0]       resultSrc,
    output logic [1:0]       aluSrcA,
    output logic [1:0]       aluSrcB,
    output logic [2:0]       aluControl,
    output logic [1:0]       immSrc,
    output logic             illegal,
    output logic [CNT_W-1:0] instret,
    output logic [3:0]       dbg_state
);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_JAL      = 4'd8,
        S_ALUWB    = 4'd9,
        S_BEQ      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALU_ADD  = 2'd0,
        ALU_SUB  = 2'd1,
        ALU_FUNC = 2'd2
    } alu_op_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] instret_q, instret_d;
    alu_op_t          alu_op;

    // State register and retired-instruction counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FETCH;
            instret_q <= '0;
        end else begin
            state_q   <= state_d;
            instret_q <= instret_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    if (memReady) state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECUTER;
                    OP_I:         state_d = S_EXECUTEI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_TRAP;
                endcase
            end
            S_MEMADR: begin
                if (op == OP_LW)      state_d = S_MEMREAD;
                else if (op == OP_SW) state_d = S_MEMWRITE;
                else                  state_d = S_FETCH;
            end
            S_MEMREAD:  if (memReady) state_d = S_MEMWB;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: if (memReady) state_d = S_FETCH;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
    end

    // An instruction retires on the edge that returns the FSM to FETCH.
    // TRAP never returns to FETCH, so a trapped instruction never counts.
    always_comb begin
        instret_d = instret_q;
        if (state_d == S_FETCH && state_q != S_FETCH) begin
            instret_d = instret_q + CNT_W'(1);
        end
    end

    // Output logic.
    always_comb begin
        memReq    = 1'b0;
        memWrite  = 1'b0;
        irWrite   = 1'b0;
        pcWrite   = 1'b0;
        regWrite  = 1'b0;
        illegal   = 1'b0;
        adrSrc    = 1'b0;
        resultSrc = 2'b00;
        aluSrcA   = 2'b00;
        aluSrcB   = 2'b00;
        alu_op    = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                memReq    = 1'b1;
                aluSrcB   = 2'b10;
                resultSrc = 2'b10;
                irWrite   = memReady;
                pcWrite   = memReady;
            end
            S_DECODE: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b01;
            end
            S_MEMADR: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
            end
            S_MEMREAD: begin
                memReq = 1'b1;
                adrSrc = 1'b1;
            end
            S_MEMWB: begin
                resultSrc = 2'b01;
                regWrite  = 1'b1;
            end
            S_MEMWRITE: begin
                memReq   = 1'b1;
                memWrite = 1'b1;
                adrSrc   = 1'b1;
            end
            S_EXECUTER: begin
                aluSrcA = 2'b10;
                alu_op  = ALU_FUNC;
            end
            S_EXECUTEI: begin
                aluSrcA = 2'b10;
                aluSrcB = 2'b01;
                alu_op  = ALU_FUNC;
            end
            S_JAL: begin
                aluSrcA = 2'b01;
                aluSrcB = 2'b10;
                pcWrite = 1'b1;
            end
            S_ALUWB:    regWrite = 1'b1;
            S_BEQ: begin
                aluSrcA = 2'b10;
                alu_op  = ALU_SUB;
                pcWrite = zero;
            end
            S_TRAP:     illegal = 1'b1;
            default:    ;
        endcase
        // Reset aborts any access in flight, even though the reset state
        // is FETCH.
        if (rst) begin
            memReq   = 1'b0;
            memWrite = 1'b0;
            irWrite  = 1'b0;
            pcWrite  = 1'b0;
            regWrite = 1'b0;
        end
    end

    // ALU control. Subtract is only chosen by funct7 for R-type (op[5]=1);
    // I-type addi with imm[10]=1 must still add.
    always_comb begin
        aluControl = 3'b000;
        case (alu_op)
            ALU_SUB:  aluControl = 3'b001;
            ALU_FUNC: begin
                case (func3)
                    3'b000:  aluControl = (op[5] & func7) ? 3'b001 : 3'b000;
                    3'b010:  aluControl = 3'b101;
                    3'b110:  aluControl = 3'b011;
                    3'b111:  aluControl = 3'b010;
                    default: aluControl = 3'b000;
                endcase
            end
            default:  aluControl = 3'b000;
        endcase
    end

    // Immediate format depends only on the opcode.
    always_comb begin
        case (op)
            OP_SW:   immSrc = 2'b01;
            OP_BEQ:  immSrc = 2'b10;
            OP_JAL:  immSrc = 2'b11;
            default: immSrc = 2'b00;
        endcase
    end

    assign instret   = instret_q;
    assign dbg_state = state_q;

endmodule
